// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 types, FSM encoding and inverse-round helper functions
package aes_pkg;

    localparam int NB_ROUNDS = 10;

    typedef logic [127:0] state_t;

    typedef enum logic [1:0] {IDLE, ROUND, LAST} fsm_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant as a sum of chained xtime terms
    function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] c);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = b;
        for (int i = 0; i < 4; i++) begin
            if (c[i]) p ^= x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic state_t inv_shift_rows(input state_t s);
        state_t o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9),
                gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd),
                gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb),
                gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he)};
    endfunction

    function automatic state_t inv_mix_columns(input state_t s);
        state_t o;
        o = '0;
        for (int c = 0; c < 4; c++)
            o[127-32*c -: 32] = inv_mix_column(s[127-32*c -: 32]);
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// aes_inv_sbox: combinational 256-entry AES inverse S-box lookup
module aes_inv_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign out_o = INV_SBOX[in_i];

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// aes_inv_cipher_iter: iterative AES-128 inverse cipher, one decryption round per clock
module aes_inv_cipher_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] cipher_in,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic         busy,
    output logic         done,
    output logic [127:0] plain_out
);

    fsm_e       fsm_q;
    logic [3:0] rnd_q;
    state_t     state_q, plain_q, isr, isb, state_d;
    logic       busy_q, done_q;

    assign isr = inv_shift_rows(state_q);

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_inv_sbox u_sbox (
            .in_i  (isr[127-8*i -: 8]),
            .out_o (isb[127-8*i -: 8])
        );
    end

    // The final round shares InvShiftRows/InvSubBytes but skips InvMixColumns
    assign state_d = inv_mix_columns(isb ^ rk);

    assign rk_idx = fsm_q == IDLE  ? 4'(NB_ROUNDS) :
                    fsm_q == ROUND ? rnd_q : 4'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= IDLE;
            rnd_q   <= '0;
            state_q <= '0;
            plain_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (fsm_q)
                IDLE: if (start) begin
                    state_q <= cipher_in ^ rk;
                    rnd_q   <= 4'(NB_ROUNDS - 1);
                    busy_q  <= 1'b1;
                    fsm_q   <= ROUND;
                end
                ROUND: begin
                    state_q <= state_d;
                    if (rnd_q == 4'd1) fsm_q <= LAST;
                    else rnd_q <= rnd_q - 4'd1;
                end
                LAST: begin
                    plain_q <= isb ^ rk;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    fsm_q   <= IDLE;
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign plain_out = plain_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// tb_aes_inv_cipher_iter: directed FIPS-197 vectors plus reference-encrypted random blocks
module tb_aes_inv_cipher_iter;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk, rst, start, busy, done;
    logic [127:0] cipher_in, rk, plain_out;
    logic [3:0]   rk_idx;
    logic [127:0] cur_rk [0:10];
    logic [7:0]   sb [256];
    logic [127:0] ct2;
    int           n_cmp, n_err, cyc;

    aes_inv_cipher_iter dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cipher_in (cipher_in),
        .rk_idx    (rk_idx),
        .rk        (rk),
        .busy      (busy),
        .done      (done),
        .plain_out (plain_out)
    );

    assign rk = rk_idx <= 4'd10 ? cur_rk[rk_idx] : '0;

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box from the field inverse and affine map, independent of the DUT table
    task automatic build_sbox();
        logic [7:0] v;
        for (int x = 0; x < 256; x++) begin
            v = '0;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
            sb[x] = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
        end
    endtask

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) cur_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [127:0] s, t;
        logic [7:0]   a0, a1, a2, a3;
        s = pt ^ cur_rk[0];
        for (int r = 1; r <= 10; r++) begin
            for (int b = 0; b < 16; b++) t[127-8*b -: 8] = sb[s[127-8*b -: 8]];
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++)
                    s[127-8*(4*c+q) -: 8] = t[127-8*(4*((c+q)%4)+q) -: 8];
            if (r < 10)
                for (int c = 0; c < 4; c++) begin
                    {a0, a1, a2, a3} = s[127-32*c -: 32];
                    s[127-32*c -: 32] = {gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
                                         a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3,
                                         a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03),
                                         gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02)};
                end
            s ^= cur_rk[r];
        end
        return s;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic dec(input logic [127:0] ct, input logic [127:0] pt, input string tag);
        int n;
        @(negedge clk);
        start = 1'b1;
        cipher_in = ct;
        @(negedge clk);
        start = 1'b0;
        cipher_in = rand128();
        n = 1;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, 128'(n), 128'(11));
        chk({tag, " plain"}, plain_out, pt);
        chk({tag, " busy@done"}, 128'(busy), 128'(0));
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        start = 1'b0;
        cipher_in = '0;
        n_cmp = 0;
        n_err = 0;
        build_sbox();
        expand(C1_KEY);
        chk("model rk10", cur_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        chk("model enc", encrypt(C1_PT), C1_CT);
        chk("fn inv_mix_column", 128'(aes_pkg::inv_mix_column(32'h8e4da1bc)), 128'hdb135345);
        chk("fn inv_shift_rows", aes_pkg::inv_shift_rows(128'h000102030405060708090a0b0c0d0e0f),
            128'h000d0a0704010e0b0805020f0c090603);

        repeat (2) @(negedge clk);
        chk("reset busy", 128'(busy), 128'(0));
        chk("reset done", 128'(done), 128'(0));
        chk("reset plain", plain_out, '0);
        chk("reset rk_idx", 128'(rk_idx), 128'(10));
        rst = 1'b0;

        // C.1 with the key-index sequence checked every cycle
        @(negedge clk);
        start = 1'b1;
        cipher_in = C1_CT;
        chk("c1 rk_idx accept", 128'(rk_idx), 128'(10));
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            cipher_in = rand128();
            chk($sformatf("c1 rk_idx cyc%0d", k), 128'(rk_idx), 128'(10 - k));
            chk($sformatf("c1 busy cyc%0d", k), 128'(busy), 128'(1));
            chk($sformatf("c1 done cyc%0d", k), 128'(done), 128'(0));
        end
        @(negedge clk);
        chk("c1 done", 128'(done), 128'(1));
        chk("c1 busy@done", 128'(busy), 128'(0));
        chk("c1 plain", plain_out, C1_PT);
        chk("c1 rk_idx idle", 128'(rk_idx), 128'(10));

        expand(B_KEY);
        dec(B_CT, B_PT, "appB");

        // start held high across a block, then a second block taken in the done cycle
        expand(C1_KEY);
        ct2 = encrypt(B_PT);
        @(negedge clk);
        start = 1'b1;
        cipher_in = C1_CT;
        cyc = 0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (done) break;
            cipher_in = rand128();
        end
        chk("hold latency", 128'(cyc), 128'(11));
        chk("hold plain", plain_out, C1_PT);
        cipher_in = ct2;
        @(negedge clk);
        start = 1'b0;
        cipher_in = rand128();
        chk("b2b done pulse", 128'(done), 128'(0));
        chk("b2b busy", 128'(busy), 128'(1));
        cyc = 1;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b spacing", 128'(cyc), 128'(11));
        chk("b2b plain", plain_out, B_PT);

        // reset while rnd=5 must abort at once
        @(negedge clk);
        start = 1'b1;
        cipher_in = C1_CT;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (rk_idx != 4'd5 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("midrst reach rnd5", 128'(rk_idx), 128'(5));
        rst = 1'b1;
        #1;
        chk("midrst busy", 128'(busy), 128'(0));
        chk("midrst done", 128'(done), 128'(0));
        chk("midrst plain", plain_out, '0);
        chk("midrst rk_idx", 128'(rk_idx), 128'(10));
        @(negedge clk);
        chk("midrst no done", 128'(done), 128'(0));
        rst = 1'b0;
        dec(C1_CT, C1_PT, "post reset");

        for (int i = 0; i < 1000; i++) begin
            logic [127:0] pt;
            pt = rand128();
            expand(rand128());
            dec(encrypt(pt), pt, $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
